bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one SRAM-like bus between the fetch-stage requester (IF) and the mem-stage requester (MEM), with one outstanding transaction at a time.
- Fixed priority: MEM beats IF.
- Generates stallreq_from_if and stallreq_from_mem for the hazard unit.
- Takes the exception flush, so an in-flight instruction fetch can be aborted or its data discarded.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched instruction; valid when if_done=1.
- if_done  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  data request; held high until mem_done.
- mem_wr  in  1  1=store, 0=load.
- mem_size  in  2  0=byte, 1=half, 2=word.
- mem_addr  in  AW  data address.
- mem_wdata  in  DW  store data.
- mem_rdata  out  DW  load data; valid when mem_done=1.
- mem_done  out  1  one-cycle completion pulse for MEM.
- flush  in  1  exception flush (except_flush).
- stallreq_from_if  out  1  = if_req & ~if_done.
- stallreq_from_mem  out  1  = mem_req & ~mem_done.
- bus_req  out  1  bus address-phase request.
- bus_wr  out  1  bus write flag.
- bus_size  out  2  bus size.
- bus_addr  out  AW  bus address.
- bus_wdata  out  DW  bus write data.
- bus_addr_ok  in  1  address accepted this cycle.
- bus_data_ok  in  1  data/response returned this cycle.
- bus_rdata  in  DW  read data; valid with bus_data_ok.

Behaviour:
- State register: IDLE, ADDR, DATA, RESP. Also owner (0=IF, 1=MEM), discard flag, latched request fields, latched rdata.
- Reset (resetn=0, asynchronous): state=IDLE, owner=0, discard=0. All latched fields and rdata are 0, so bus_req, if_done and mem_done are 0 and if_rdata, mem_rdata and bus_* are 0. A reset in the middle of a transaction returns to IDLE immediately.
- IDLE:
  - If mem_req=1: grant MEM and latch mem_wr, mem_size, mem_addr, mem_wdata.
  - Else if if_req=1 and flush=0: grant IF and latch wr=0, size=2, if_addr.
  - On a grant, go to ADDR. No bus activity happens in IDLE.
- ADDR:
  - bus_req=1 and bus_* are driven from the latched fields, which stay stable while waiting.
  - On bus_addr_ok=1, go to DATA.
  - If owner=IF and flush=1 with bus_addr_ok=0: abort and go to IDLE; no done pulse.
  - If owner=IF and flush=1 with bus_addr_ok=1: go to DATA with discard=1.
- DATA:
  - bus_req=0.
  - If owner=IF and flush=1, set discard=1.
  - On bus_data_ok=1, latch bus_rdata into the owner's rdata register.
    - discard=1: go to IDLE and clear discard; no done pulse.
    - Otherwise: go to RESP.
- RESP (exactly one cycle):
  - The owner's done=1 and its rdata holds the latched value.
  - If owner=IF and flush=1 in this cycle, if_done is forced to 0.
  - Always go to IDLE next.
  - No new grant is made in RESP, because the requester still presents the completed request this cycle.
- Latency: with addr_ok and data_ok both arriving in their first possible cycle, req (cycle 0) leads to done in cycle 3. A back-to-back request from the same requester is granted in the cycle after done.
- Rdata registers hold their value until the next completion for the same owner.
- Flush never affects MEM-owned transactions. Stores and loads that have been granted complete normally; upstream gates mem_req on exceptions.
- Both requests arriving in the same IDLE cycle: MEM is granted and IF stays stalled.
- A request dropped while it is pending (not granted yet): simply not granted.
- A request dropped after its grant: the transaction still completes. The done pulse is still produced, except for IF under flush.
- bus_data_ok outside DATA is ignored. bus_addr_ok outside ADDR is ignored.

Test Plan:
- Single fetch: if_req=1, if_addr=0xBFC00000; addr_ok in cycle 1, data_ok with rdata=0x3C080001 in cycle 2 -> bus_req=1 only in cycle 1; if_done=1 in cycle 3 with if_rdata=0x3C080001; stallreq_from_if=1 in cycles 0-2 and 0 in cycle 3.
- Contention: if_req and mem_req (wr=1, addr=0x80000010, wdata=0xDEADBEEF, size=2) both raised in cycle 0 -> the bus carries the store first; mem_done arrives, then the IF transaction is granted one cycle later; stallreq_from_if stays 1 throughout.
- Wait states: addr_ok delayed 3 cycles and data_ok delayed 2 more -> bus_addr and bus_wdata stay stable while bus_req=1; done is asserted exactly one cycle after data_ok.
- Flush in ADDR: IF owner with flush=1 and addr_ok=0 -> state returns to IDLE, bus_req drops, no if_done; the next if_req (0xBFC00380) is granted.
- Flush in DATA: IF owner, flush pulsed before data_ok -> data_ok is consumed, if_done never pulses, if_rdata is not used, and a new grant can occur in the cycle after data_ok.
- Reset mid-transaction: resetn=0 in DATA -> bus_req, if_done and mem_done are 0 immediately; after release, a fresh mem_req load is granted and completes with the correct mem_rdata.

Source files
------------

// File: rtl/bus_arbiter.sv
// Shares one SRAM-like bus between fetch (IF) and memory (MEM) requesters.
// MEM has fixed priority; one outstanding transaction; IF can be flushed.
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          mem_req,
  input  logic          mem_wr,
  input  logic [1:0]    mem_size,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  input  logic          flush,
  output logic          stallreq_from_if,
  output logic          stallreq_from_mem,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          discard_q, discard_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, mem_rdata_q;
  logic          if_flush;
  logic          data_hit;

  // flush only ever touches fetch-owned transactions
  assign if_flush = ~owner_q & flush;
  assign data_hit = (state_q == DATA) & bus_data_ok;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    discard_d = discard_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          owner_d = 1'b1;
          wr_d    = mem_wr;
          size_d  = mem_size;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          state_d = ADDR;
        end else if (if_req && !flush) begin
          owner_d = 1'b0;
          wr_d    = 1'b0;
          size_d  = 2'd2;
          addr_d  = if_addr;
          wdata_d = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          state_d   = DATA;
          discard_d = if_flush;
        end else if (if_flush) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (if_flush) discard_d = 1'b1;
        if (bus_data_ok) begin
          discard_d = 1'b0;
          if (discard_q || if_flush) state_d = IDLE;
          else state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      discard_q <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      discard_q <= discard_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else if (data_hit) begin
      if (owner_q) mem_rdata_q <= bus_rdata;
      else if_rdata_q <= bus_rdata;
    end
  end

  assign bus_req   = (state_q == ADDR);
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  assign if_done  = (state_q == RESP) & ~owner_q & ~flush;
  assign mem_done = (state_q == RESP) & owner_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  assign stallreq_from_if  = if_req & ~if_done;
  assign stallreq_from_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: scoreboard of completions plus
// cycle-exact checks of bus phases, stalls, flush and reset.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        flush;
  logic        stallreq_from_if;
  logic        stallreq_from_mem;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] resp_data;

  int   addr_dly = 0;
  int   data_dly = 0;
  int   acnt = 0;
  int   dcnt = 0;
  logic pend = 1'b0;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic        own;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // bus slave with programmable address/data wait states
  wire        bus_addr_ok = bus_req && (acnt >= addr_dly);
  wire        bus_data_ok = pend && (dcnt >= data_dly);
  wire [31:0] bus_rdata   = bus_data_ok ? resp_data : 32'h0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acnt <= 0;
      dcnt <= 0;
      pend <= 1'b0;
    end else begin
      if (bus_req && !bus_addr_ok) acnt <= acnt + 1;
      else acnt <= 0;
      if (bus_req && bus_addr_ok) begin
        pend <= 1'b1;
        dcnt <= 0;
      end else if (bus_data_ok) begin
        pend <= 1'b0;
      end else if (pend) begin
        dcnt <= dcnt + 1;
      end
    end
  end

  bus_arbiter dut (
    .clk               (clk),
    .resetn            (resetn),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_rdata          (if_rdata),
    .if_done           (if_done),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_done          (mem_done),
    .flush             (flush),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_mem (stallreq_from_mem),
    .bus_req           (bus_req),
    .bus_wr            (bus_wr),
    .bus_size          (bus_size),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_addr_ok       (bus_addr_ok),
    .bus_data_ok       (bus_data_ok),
    .bus_rdata         (bus_rdata)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic o, input logic c,
                      input logic [31:0] d);
    exp_t e;
    e.own  = o;
    e.chk  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // completion monitor
  always @(negedge clk) begin
    exp_t e;
    if (if_done || mem_done) begin
      vectors++;
      if (if_done && mem_done) begin
        errors++;
        $display("FAIL dual_done: if_done=1 mem_done=1 expected one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: if_done=%b mem_done=%b expected none",
                 if_done, mem_done);
      end else begin
        e = sb.pop_front();
        if (e.own !== mem_done) begin
          errors++;
          $display("FAIL done_owner: got mem_done=%b expected owner=%b",
                   mem_done, e.own);
        end else if (e.chk &&
                     ((mem_done ? mem_rdata : if_rdata) !== e.data)) begin
          errors++;
          $display("FAIL done_rdata: got %h expected %h",
                   mem_done ? mem_rdata : if_rdata, e.data);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    mem_req = 1'b0;
    mem_wr = 1'b0;
    mem_size = '0;
    mem_addr = '0;
    mem_wdata = '0;
    flush = 1'b0;
    resp_data = '0;

    // reset state
    nxt();
    smp();
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_if_done", if_done, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    nxt();
    resetn = 1'b1;
    nxt();

    // single fetch
    nxt();
    if_req = 1'b1;
    if_addr = 32'hBFC00000;
    resp_data = 32'h3C080001;
    push(1'b0, 1'b1, 32'h3C080001);
    smp();
    check("t1_c0_bus_req", bus_req, 0);
    check("t1_c0_stall", stallreq_from_if, 1);
    nxt(); smp();
    check("t1_c1_bus_req", bus_req, 1);
    check("t1_c1_bus_addr", bus_addr, 32'hBFC00000);
    check("t1_c1_bus_size", bus_size, 2);
    check("t1_c1_bus_wr", bus_wr, 0);
    check("t1_c1_stall", stallreq_from_if, 1);
    nxt(); smp();
    check("t1_c2_bus_req", bus_req, 0);
    check("t1_c2_stall", stallreq_from_if, 1);
    nxt(); smp();
    check("t1_c3_if_done", if_done, 1);
    check("t1_c3_if_rdata", if_rdata, 32'h3C080001);
    check("t1_c3_stall", stallreq_from_if, 0);
    nxt();
    if_req = 1'b0;

    // contention: store wins, then fetch
    nxt();
    if_req = 1'b1;
    if_addr = 32'hBFC00004;
    mem_req = 1'b1;
    mem_wr = 1'b1;
    mem_size = 2'd2;
    mem_addr = 32'h80000010;
    mem_wdata = 32'hDEADBEEF;
    resp_data = 32'h0;
    push(1'b1, 1'b0, 32'h0);
    push(1'b0, 1'b1, 32'h24020005);
    smp();
    check("t2_c0_stall_if", stallreq_from_if, 1);
    nxt(); smp();
    check("t2_c1_bus_req", bus_req, 1);
    check("t2_c1_bus_wr", bus_wr, 1);
    check("t2_c1_bus_addr", bus_addr, 32'h80000010);
    check("t2_c1_bus_wdata", bus_wdata, 32'hDEADBEEF);
    check("t2_c1_bus_size", bus_size, 2);
    check("t2_c1_stall_if", stallreq_from_if, 1);
    nxt(); smp();
    check("t2_c2_stall_if", stallreq_from_if, 1);
    nxt(); smp();
    check("t2_c3_mem_done", mem_done, 1);
    check("t2_c3_if_done", if_done, 0);
    check("t2_c3_stall_if", stallreq_from_if, 1);
    nxt();
    mem_req = 1'b0;
    mem_wr = 1'b0;
    resp_data = 32'h24020005;
    smp();
    check("t2_c4_bus_req", bus_req, 0);
    check("t2_c4_stall_if", stallreq_from_if, 1);
    nxt(); smp();
    check("t2_c5_bus_req", bus_req, 1);
    check("t2_c5_bus_addr", bus_addr, 32'hBFC00004);
    check("t2_c5_bus_wr", bus_wr, 0);
    nxt(); smp();
    check("t2_c6_stall_if", stallreq_from_if, 1);
    nxt(); smp();
    check("t2_c7_if_done", if_done, 1);
    check("t2_c7_stall_if", stallreq_from_if, 0);
    nxt();
    if_req = 1'b0;

    // wait states on a halfword load
    nxt();
    mem_req = 1'b1;
    mem_wr = 1'b0;
    mem_size = 2'd1;
    mem_addr = 32'h80000022;
    mem_wdata = 32'h0;
    addr_dly = 3;
    data_dly = 2;
    resp_data = 32'h0000ABCD;
    push(1'b1, 1'b1, 32'h0000ABCD);
    smp();
    for (int i = 1; i <= 4; i++) begin
      nxt(); smp();
      check("t3_addr_bus_req", bus_req, 1);
      check("t3_addr_bus_addr", bus_addr, 32'h80000022);
      check("t3_addr_bus_size", bus_size, 1);
    end
    for (int i = 5; i <= 7; i++) begin
      nxt(); smp();
      check("t3_data_bus_req", bus_req, 0);
      check("t3_data_mem_done", mem_done, 0);
      check("t3_data_stall_mem", stallreq_from_mem, 1);
    end
    nxt(); smp();
    check("t3_c8_mem_done", mem_done, 1);
    check("t3_c8_stall_mem", stallreq_from_mem, 0);
    check("t3_c8_if_rdata_hold", if_rdata, 32'h24020005);
    nxt();
    mem_req = 1'b0;
    addr_dly = 0;
    data_dly = 0;

    // flush while waiting for address accept
    nxt();
    if_req = 1'b1;
    if_addr = 32'hBFC00100;
    addr_dly = 99;
    smp();
    nxt(); smp();
    check("t4_c1_bus_req", bus_req, 1);
    nxt();
    flush = 1'b1;
    smp();
    check("t4_c2_if_done", if_done, 0);
    nxt();
    flush = 1'b0;
    if_addr = 32'hBFC00380;
    addr_dly = 0;
    resp_data = 32'h00000380;
    smp();
    check("t4_c3_bus_req", bus_req, 0);
    nxt();
    push(1'b0, 1'b1, 32'h00000380);
    smp();
    check("t4_c4_bus_req", bus_req, 1);
    check("t4_c4_bus_addr", bus_addr, 32'hBFC00380);
    nxt(); smp();
    nxt(); smp();
    check("t4_c6_if_done", if_done, 1);
    nxt();
    if_req = 1'b0;

    // flush pulsed during the data phase
    nxt();
    if_req = 1'b1;
    if_addr = 32'hBFC00200;
    data_dly = 2;
    resp_data = 32'hBAD0BAD0;
    smp();
    nxt(); smp();
    check("t5_c1_bus_req", bus_req, 1);
    nxt();
    flush = 1'b1;
    smp();
    check("t5_c2_bus_req", bus_req, 0);
    nxt();
    flush = 1'b0;
    smp();
    nxt(); smp();
    check("t5_c4_if_done", if_done, 0);
    nxt();
    if_addr = 32'hBFC00380;
    data_dly = 0;
    resp_data = 32'h8C020000;
    smp();
    check("t5_c5_if_done", if_done, 0);
    check("t5_c5_bus_req", bus_req, 0);
    check("t5_c5_stall_if", stallreq_from_if, 1);
    nxt();
    push(1'b0, 1'b1, 32'h8C020000);
    smp();
    check("t5_c6_bus_req", bus_req, 1);
    check("t5_c6_bus_addr", bus_addr, 32'hBFC00380);
    nxt(); smp();
    nxt(); smp();
    check("t5_c8_if_done", if_done, 1);
    check("t5_c8_if_rdata", if_rdata, 32'h8C020000);
    nxt();
    if_req = 1'b0;

    // reset in the middle of a load
    nxt();
    mem_req = 1'b1;
    mem_wr = 1'b0;
    mem_size = 2'd2;
    mem_addr = 32'h80000040;
    data_dly = 5;
    resp_data = 32'h55AA55AA;
    smp();
    nxt(); smp();
    check("t6_c1_bus_req", bus_req, 1);
    nxt(); smp();
    nxt();
    resetn = 1'b0;
    mem_req = 1'b0;
    smp();
    check("t6_rst_bus_req", bus_req, 0);
    check("t6_rst_mem_done", mem_done, 0);
    check("t6_rst_if_done", if_done, 0);
    check("t6_rst_bus_addr", bus_addr, 0);
    check("t6_rst_mem_rdata", mem_rdata, 0);
    check("t6_rst_if_rdata", if_rdata, 0);
    nxt();
    resetn = 1'b1;
    smp();
    nxt();
    mem_req = 1'b1;
    mem_addr = 32'h80000044;
    data_dly = 0;
    resp_data = 32'h12345678;
    push(1'b1, 1'b1, 32'h12345678);
    smp();
    check("t6_c5_bus_req", bus_req, 0);
    nxt(); smp();
    check("t6_c6_bus_req", bus_req, 1);
    check("t6_c6_bus_addr", bus_addr, 32'h80000044);
    nxt(); smp();
    nxt(); smp();
    check("t6_c8_mem_done", mem_done, 1);
    check("t6_c8_mem_rdata", mem_rdata, 32'h12345678);
    nxt();
    mem_req = 1'b0;

    repeat (3) nxt();
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
